// File: rtl/ddr4_pkg.sv
// ---------------------------------------------------------------------------
// ddr4_pkg
// Shared definitions for the DDR4 host command generator:
//   cmdgen_state_t  - command sequencer states
//   lookup_t        - open-page table classification of a request
//   RAS_CAS_WE_*    - A16..A14 (ras_n, cas_n, we_n) patterns for PRE/RD/WR
//   A10_POS         - A10 (auto-precharge / all-bank) pin position
//   CNT_WIDTH       - width of the command spacing down-counter
// ---------------------------------------------------------------------------
package ddr4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_RP,
        ST_ACT,
        ST_WAIT_RCD,
        ST_CMD
    } cmdgen_state_t;

    typedef enum logic [1:0] {
        LK_EMPTY,
        LK_HIT,
        LK_MISS
    } lookup_t;

    localparam logic [2:0] RAS_CAS_WE_PRE = 3'b010;
    localparam logic [2:0] RAS_CAS_WE_RD  = 3'b101;
    localparam logic [2:0] RAS_CAS_WE_WR  = 3'b100;

    localparam int A10_POS   = 10;
    localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/bank_row_table.sv
// ---------------------------------------------------------------------------
// bank_row_table
// Open-page table: one {valid, row} entry per bank ({bg,ba} index).
// Ports:
//   clk, reset          - clock, synchronous active-high reset (clears valid)
//   set_en/set_bank/set_row - mark an entry open with a row (ACT issued)
//   clr_en/clr_bank         - mark an entry closed (PRE issued)
//   lk_bank/lk_row          - combinational lookup key
//   lk_result               - LK_HIT / LK_EMPTY / LK_MISS for the key
// ---------------------------------------------------------------------------
module bank_row_table
    import ddr4_pkg::*;
#(
    parameter int BANKW = 4,
    parameter int ROWW  = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [BANKW-1:0] set_bank,
    input  logic [ROWW-1:0]  set_row,
    input  logic             clr_en,
    input  logic [BANKW-1:0] clr_bank,
    input  logic [BANKW-1:0] lk_bank,
    input  logic [ROWW-1:0]  lk_row,
    output lookup_t          lk_result
);

    localparam int NBANKS = 1 << BANKW;

    logic [NBANKS-1:0] valid_reg;
    logic [ROWW-1:0]   row_reg [NBANKS];
    logic [NBANKS-1:0] set_sel;
    logic [NBANKS-1:0] clr_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NBANKS; gi++) begin : g_dec
            assign set_sel[gi] = set_en && (set_bank == BANKW'(gi));
            assign clr_sel[gi] = clr_en && (clr_bank == BANKW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < NBANKS; i++) begin
                if (set_sel[i]) begin
                    valid_reg[i] <= 1'b1;
                end else if (clr_sel[i]) begin
                    valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Row contents only matter while the entry is valid, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBANKS; i++) begin
            if (set_sel[i]) begin
                row_reg[i] <= set_row;
            end
        end
    end

    always_comb begin
        lk_result = LK_EMPTY;
        if (valid_reg[lk_bank]) begin
            lk_result = (row_reg[lk_bank] == lk_row) ? LK_HIT : LK_MISS;
        end
    end

endmodule

// File: rtl/ddr4_cmd_gen.sv
// ---------------------------------------------------------------------------
// ddr4_cmd_gen
// Host-side DDR4 command generator. Accepts single read/write requests over a
// valid/ready handshake and drives PRE/ACT/RD/WR on the DIMM command pins,
// tracking open rows per bank and enforcing tRP, tRCD and tCCD spacing.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake
//   req_wr/bg/ba/row/col     - request fields, sampled on the handshake only
//   stall                    - from DIMM, high = do not issue commands
//   done/done_hit            - one-cycle pulse with the RD/WR, hit flag
//   cke, cs_n, act_n, A, bg, ba - DIMM command pins (all registered)
//
// The state register names the sequencer position; a command that becomes
// eligible is written straight into the registered pins, so a command
// decided in cycle c is on the pins in cycle c+1. When stall blocks an
// eligible command the FSM parks in PRE/ACT/CMD (driving DES) until stall
// is sampled low.
// ---------------------------------------------------------------------------
module ddr4_cmd_gen
    import ddr4_pkg::*;
#(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRP       = 4,
    parameter int TRCD      = 4,
    parameter int TCCD      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    input  logic                 stall,
    output logic                 done,
    output logic                 done_hit,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba
);

    localparam int BANKW = BGWIDTH + BAWIDTH;
    localparam logic [CNT_WIDTH-1:0] TRP_LOAD  = CNT_WIDTH'(TRP - 1);
    localparam logic [CNT_WIDTH-1:0] TRCD_LOAD = CNT_WIDTH'(TRCD - 1);
    localparam logic [CNT_WIDTH-1:0] TCCD_LOAD = CNT_WIDTH'(TCCD - 1);

    // Sequencer state and spacing counter
    cmdgen_state_t         state_reg, state_next;
    cmdgen_state_t         want;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;

    // Latched request
    logic                  lat_wr_reg;
    logic [BGWIDTH-1:0]    lat_bg_reg;
    logic [BAWIDTH-1:0]    lat_ba_reg;
    logic [ADDRWIDTH-1:0]  lat_row_reg;
    logic [COLWIDTH-1:0]   lat_col_reg;
    logic                  lat_hit_reg;

    // Registered outputs
    logic                  ready_reg, ready_next;
    logic                  cke_reg;
    logic                  cs_n_reg, cs_n_next;
    logic                  act_n_reg, act_n_next;
    logic [ADDRWIDTH-1:0]  a_reg, a_next;
    logic [BGWIDTH-1:0]    bg_reg, bg_next;
    logic [BAWIDTH-1:0]    ba_reg, ba_next;
    logic                  done_reg, done_next;
    logic                  done_hit_reg, done_hit_next;

    // Request currently being worked on: the live inputs on the handshake
    // cycle (so the first command can issue immediately), else the latch.
    logic                  handshake;
    logic                  cur_wr;
    logic [BGWIDTH-1:0]    cur_bg;
    logic [BAWIDTH-1:0]    cur_ba;
    logic [ADDRWIDTH-1:0]  cur_row;
    logic [COLWIDTH-1:0]   cur_col;
    logic                  cur_hit;

    logic                  tbl_set;
    logic                  tbl_clr;
    lookup_t               lk_result;

    logic [ADDRWIDTH-1:0]  pre_word;
    logic [ADDRWIDTH-1:0]  rdwr_word;

    assign handshake = (state_reg == ST_IDLE) && req_valid && ready_reg;
    assign cur_wr    = handshake ? req_wr  : lat_wr_reg;
    assign cur_bg    = handshake ? req_bg  : lat_bg_reg;
    assign cur_ba    = handshake ? req_ba  : lat_ba_reg;
    assign cur_row   = handshake ? req_row : lat_row_reg;
    assign cur_col   = handshake ? req_col : lat_col_reg;
    assign cur_hit   = handshake ? (lk_result == LK_HIT) : lat_hit_reg;

    bank_row_table #(
        .BANKW (BANKW),
        .ROWW  (ADDRWIDTH)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .set_en    (tbl_set),
        .set_bank  ({cur_bg, cur_ba}),
        .set_row   (cur_row),
        .clr_en    (tbl_clr),
        .clr_bank  ({cur_bg, cur_ba}),
        .lk_bank   ({req_bg, req_ba}),
        .lk_row    (req_row),
        .lk_result (lk_result)
    );

    // Command address words
    always_comb begin
        pre_word                           = '0;
        pre_word[ADDRWIDTH-1 -: 3]         = RAS_CAS_WE_PRE;
        pre_word[A10_POS]                  = 1'b0;

        rdwr_word                          = '0;
        rdwr_word[COLWIDTH-1:0]            = cur_col;
        rdwr_word[A10_POS]                 = 1'b0;
        rdwr_word[ADDRWIDTH-1 -: 3]        = cur_wr ? RAS_CAS_WE_WR : RAS_CAS_WE_RD;
    end

    // Next-state and output decode
    always_comb begin
        state_next    = state_reg;
        cnt_next      = (cnt_reg == '0) ? '0 : cnt_reg - 1'b1;
        want          = ST_IDLE;
        cs_n_next     = 1'b1;
        act_n_next    = 1'b1;
        a_next        = '0;
        bg_next       = '0;
        ba_next       = '0;
        done_next     = 1'b0;
        done_hit_next = 1'b0;
        tbl_set       = 1'b0;
        tbl_clr       = 1'b0;

        // Which command (if any) is eligible this cycle
        case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    case (lk_result)
                        LK_HIT:  want = ST_CMD;
                        LK_MISS: want = ST_PRE;
                        default: want = ST_ACT;
                    endcase
                end
            end
            ST_WAIT_RP:  if (cnt_reg == '0) want = ST_ACT;
            ST_WAIT_RCD: if (cnt_reg == '0) want = ST_CMD;
            ST_PRE, ST_ACT, ST_CMD: want = state_reg;
            default: state_next = ST_IDLE;
        endcase

        if (want != ST_IDLE) begin
            if (stall) begin
                // Park on the blocked command; pins stay DES.
                state_next = want;
            end else begin
                cs_n_next = 1'b0;
                bg_next   = cur_bg;
                ba_next   = cur_ba;
                case (want)
                    ST_PRE: begin
                        a_next     = pre_word;
                        cnt_next   = TRP_LOAD;
                        tbl_clr    = 1'b1;
                        state_next = ST_WAIT_RP;
                    end
                    ST_ACT: begin
                        act_n_next = 1'b0;
                        a_next     = cur_row;
                        cnt_next   = TRCD_LOAD;
                        tbl_set    = 1'b1;
                        state_next = ST_WAIT_RCD;
                    end
                    default: begin
                        a_next        = rdwr_word;
                        done_next     = 1'b1;
                        done_hit_next = cur_hit;
                        cnt_next      = TCCD_LOAD;
                        state_next    = ST_IDLE;
                    end
                endcase
            end
        end

        // Ready is registered, so it is predicted from the next state/count.
        ready_next = (state_next == ST_IDLE) && (cnt_next == '0) && !stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            ready_reg    <= 1'b0;
            cke_reg      <= 1'b0;
            cs_n_reg     <= 1'b1;
            act_n_reg    <= 1'b1;
            a_reg        <= '0;
            bg_reg       <= '0;
            ba_reg       <= '0;
            done_reg     <= 1'b0;
            done_hit_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ready_reg    <= ready_next;
            cke_reg      <= 1'b1;
            cs_n_reg     <= cs_n_next;
            act_n_reg    <= act_n_next;
            a_reg        <= a_next;
            bg_reg       <= bg_next;
            ba_reg       <= ba_next;
            done_reg     <= done_next;
            done_hit_reg <= done_hit_next;
        end
    end

    // Request latch: data only, qualified by the handshake.
    always_ff @(posedge clk) begin
        if (handshake) begin
            lat_wr_reg  <= req_wr;
            lat_bg_reg  <= req_bg;
            lat_ba_reg  <= req_ba;
            lat_row_reg <= req_row;
            lat_col_reg <= req_col;
            lat_hit_reg <= (lk_result == LK_HIT);
        end
    end

    assign req_ready = ready_reg;
    assign cke       = cke_reg;
    assign cs_n      = cs_n_reg;
    assign act_n     = act_n_reg;
    assign A         = a_reg;
    assign bg        = bg_reg;
    assign ba        = ba_reg;
    assign done      = done_reg;
    assign done_hit  = done_hit_reg;

endmodule
